// File: rtl/sign_pkg.sv
// Shared code points and qualification-FSM state type for the sign character buffer.
package sign_pkg;

    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] CODE_NONE  = 6'd0;
    localparam logic [CODE_W-1:0] CODE_CLEAR = 6'd63;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        LATCHED = 2'd2
    } sign_state_t;

endpackage

// File: rtl/char_fifo.sv
// Sync FWFT FIFO: written data is visible on head the cycle after the push edge.
// Flush beats pop and push; push when full without pop is dropped and flagged for one cycle.
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic             drop_next;

    assign valid = (count != '0);
    assign full  = (count == DEPTH_N);
    assign head  = valid ? mem[rd_ptr] : '0;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        do_pop    = pop && valid && !flush;
        do_push   = push && !flush && (!full || do_pop);
        drop_next = push && !flush && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= drop_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/sign_char_buffer.sv
// Debounces letter codes (STABLE_CYCLES matching valid samples) and queues each held sign once.
// Push/flush happen on the qualifying edge; consumer backpressure via OUT_READY, overflow reported on DROP.
module sign_char_buffer
    import sign_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CODE_W-1:0]        IN_DATA,
    input  logic                     IN_VALID,
    input  logic                     OUT_READY,
    output logic [CODE_W-1:0]        OUT_DATA,
    output logic                     OUT_VALID,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     DROP
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

    sign_state_t       state;
    logic [CODE_W-1:0] cand;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              nonzero;
    logic              same;
    logic              held;
    logic              qual;
    logic              push;
    logic              flush;

    // A held sign (LATCHED, same code) never re-qualifies, so it pushes exactly once.
    always_comb begin
        nonzero  = (IN_DATA != CODE_NONE);
        same     = (state != IDLE) && (IN_DATA == cand);
        held     = (state == LATCHED) && same;
        cnt_next = (state == QUALIFY && same) ? stable_cnt + CNT_W'(1) : CNT_W'(1);
        qual     = IN_VALID && nonzero && !held && (cnt_next == STABLE_N);
        push     = qual && (IN_DATA != CODE_CLEAR);
        flush    = qual && (IN_DATA == CODE_CLEAR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cand       <= CODE_NONE;
            stable_cnt <= '0;
        end else if (IN_VALID) begin
            if (!nonzero) begin
                state      <= IDLE;
                cand       <= CODE_NONE;
                stable_cnt <= '0;
            end else if (!held) begin
                cand       <= IN_DATA;
                stable_cnt <= cnt_next;
                state      <= qual ? LATCHED : QUALIFY;
            end
        end
    end

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (IN_DATA),
        .pop       (OUT_READY),
        .flush     (flush),
        .head      (OUT_DATA),
        .valid     (OUT_VALID),
        .count     (COUNT),
        .full      (FULL),
        .drop      (DROP)
    );

endmodule

// File: tb/tb_sign_char_buffer.sv
// Bench for sign_char_buffer: run-length reference model plus directed literal scenarios and random traffic.
module tb_sign_char_buffer;

    localparam int DEPTH  = 16;
    localparam int STABLE = 3;

    logic       CLK;
    logic       RST;
    logic [5:0] IN_DATA;
    logic       IN_VALID;
    logic       OUT_READY;
    logic [5:0] OUT_DATA;
    logic       OUT_VALID;
    logic [4:0] COUNT;
    logic       FULL;
    logic       DROP;

    sign_char_buffer #(.DEPTH(DEPTH), .STABLE_CYCLES(STABLE)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .DROP      (DROP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: a code qualifies when its run of consecutive valid samples reaches exactly STABLE.
    logic [5:0] mq[$];
    logic [5:0] run_code = 6'd0;
    int         run_len  = 0;
    bit         m_drop   = 1'b0;
    bit         m_qual;
    bit         m_pop;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            run_code = 6'd0;
            run_len  = 0;
            m_drop   = 1'b0;
        end else begin
            m_qual = 1'b0;
            m_pop  = OUT_READY && (mq.size() != 0);
            if (IN_VALID) begin
                if (IN_DATA == 6'd0) begin
                    run_code = 6'd0;
                    run_len  = 0;
                end else if (IN_DATA == run_code && run_len > 0) begin
                    if (run_len <= STABLE) run_len++;
                end else begin
                    run_code = IN_DATA;
                    run_len  = 1;
                end
                m_qual = (IN_DATA != 6'd0) && (run_len == STABLE);
            end
            m_drop = 1'b0;
            if (m_qual && IN_DATA == 6'd63) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_qual) begin
                    if (mq.size() < DEPTH) mq.push_back(IN_DATA);
                    else m_drop = 1'b1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_count", COUNT, mq.size());
            chk("model_valid", OUT_VALID, mq.size() != 0);
            chk("model_data", OUT_DATA, (mq.size() != 0) ? mq[0] : 0);
            chk("model_full", FULL, mq.size() == DEPTH);
            chk("model_drop", DROP, m_drop);
        end
    end

    task automatic cyc(input bit v, input logic [5:0] d, input bit r, input bit rs = 1'b0);
        IN_VALID  = v;
        IN_DATA   = d;
        OUT_READY = r;
        RST       = rs;
        @(negedge CLK);
    endtask

    task automatic qualify(input logic [5:0] code, input bit r);
        repeat (STABLE) cyc(1'b1, code, r);
    endtask

    task automatic do_reset();
        cyc(1'b0, 6'd0, 1'b0, 1'b1);
    endtask

    int         hold;
    logic [5:0] rcode;
    int         sel;

    initial begin
        IN_VALID  = 1'b0;
        IN_DATA   = 6'd0;
        OUT_READY = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        chk_en = 1'b1;

        // Reset state
        chk("rst_count", COUNT, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_data", OUT_DATA, 0);
        chk("rst_full", FULL, 0);
        chk("rst_drop", DROP, 0);

        // Three samples of 5 -> one entry, visible right after the third edge
        cyc(1'b1, 6'd5, 1'b0);
        cyc(1'b1, 6'd5, 1'b0);
        chk("q5_before", COUNT, 0);
        cyc(1'b1, 6'd5, 1'b0);
        chk("q5_count", COUNT, 1);
        chk("q5_valid", OUT_VALID, 1);
        chk("q5_data", OUT_DATA, 5);

        // Held sign pushes once; re-presenting after a 0 pushes again
        do_reset();
        repeat (10) cyc(1'b1, 6'd5, 1'b0);
        chk("hold_once", COUNT, 1);
        cyc(1'b1, 6'd0, 1'b0);
        qualify(6'd5, 1'b0);
        chk("hold_twice", COUNT, 2);
        chk("hold_head", OUT_DATA, 5);

        do_reset();
        cyc(1'b1, 6'd5, 1'b0);
        cyc(1'b1, 6'd5, 1'b0);
        qualify(6'd6, 1'b0);
        chk("restart_count", COUNT, 1);
        chk("restart_head", OUT_DATA, 6);

        // Gaps with IN_VALID=0 do not break a run
        do_reset();
        cyc(1'b1, 6'd7, 1'b0);
        cyc(1'b0, 6'd9, 1'b0);
        cyc(1'b1, 6'd7, 1'b0);
        cyc(1'b0, 6'd0, 1'b0);
        cyc(1'b1, 6'd7, 1'b0);
        chk("gap_count", COUNT, 1);
        chk("gap_head", OUT_DATA, 7);

        // Fill, overflow, then push+pop at full
        do_reset();
        for (int k = 1; k <= 16; k++) qualify(6'(k), 1'b0);
        chk("fill_count", COUNT, 16);
        chk("fill_full", FULL, 1);
        qualify(6'd17, 1'b0);
        chk("ovf_drop", DROP, 1);
        chk("ovf_count", COUNT, 16);
        cyc(1'b0, 6'd0, 1'b0);
        chk("ovf_drop_end", DROP, 0);
        cyc(1'b1, 6'd18, 1'b0);
        cyc(1'b1, 6'd18, 1'b0);
        cyc(1'b1, 6'd18, 1'b1);
        chk("pp_count", COUNT, 16);
        chk("pp_full", FULL, 1);
        chk("pp_drop", DROP, 0);
        for (int k = 2; k <= 16; k++) begin
            chk("drain_order", OUT_DATA, k);
            cyc(1'b0, 6'd0, 1'b1);
        end
        chk("drain_last", OUT_DATA, 18);
        cyc(1'b0, 6'd0, 1'b1);
        chk("drain_empty", COUNT, 0);
        cyc(1'b0, 6'd0, 1'b1);
        chk("pop_empty_ignored", COUNT, 0);
        chk("empty_data", OUT_DATA, 0);

        // Clear code flushes, overriding the same-edge pop
        do_reset();
        qualify(6'd1, 1'b0);
        qualify(6'd2, 1'b0);
        qualify(6'd3, 1'b0);
        chk("clr_pre", COUNT, 3);
        cyc(1'b1, 6'd63, 1'b0);
        cyc(1'b1, 6'd63, 1'b0);
        cyc(1'b1, 6'd63, 1'b1);
        chk("clr_count", COUNT, 0);
        chk("clr_valid", OUT_VALID, 0);
        chk("clr_data", OUT_DATA, 0);
        chk("clr_drop", DROP, 0);
        qualify(6'd4, 1'b0);
        chk("after_clr_head", OUT_DATA, 4);

        // Reset mid-qualification restarts the run
        do_reset();
        for (int k = 1; k <= 4; k++) qualify(6'(k), 1'b0);
        chk("mid_pre", COUNT, 4);
        cyc(1'b1, 6'd9, 1'b0);
        cyc(1'b1, 6'd9, 1'b0);
        cyc(1'b1, 6'd9, 1'b1, 1'b1);
        chk("mid_count", COUNT, 0);
        chk("mid_valid", OUT_VALID, 0);
        chk("mid_data", OUT_DATA, 0);
        chk("mid_full", FULL, 0);
        chk("mid_drop", DROP, 0);
        cyc(1'b1, 6'd9, 1'b0);
        cyc(1'b1, 6'd9, 1'b0);
        chk("mid_nopush", COUNT, 0);
        cyc(1'b1, 6'd9, 1'b0);
        chk("mid_third", COUNT, 1);

        // Random traffic: short runs, occasional clears, zeros and resets
        hold  = 0;
        rcode = 6'd0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 19);
                if (sel == 0)      rcode = 6'd63;
                else if (sel < 3)  rcode = 6'd0;
                else if (sel < 16) rcode = 6'($urandom_range(1, 6));
                else               rcode = 6'($urandom_range(1, 62));
                hold = $urandom_range(1, 6);
            end
            cyc($urandom_range(0, 3) != 0, rcode,
                (i % 1000 < 500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7),
                $urandom_range(0, 299) == 0);
            hold--;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sign_char_buffer.md
SIGN_CHAR_BUFFER -- requirements
Module: sign_char_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 3, consecutive matching valid samples needed to accept a code (>=1).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  synchronous active-high reset.
REQ-006 SHALL have port IN_DATA  input  6  letter code from memory read stage (OUT of memory).
REQ-007 SHALL have port IN_VALID  input  1  IN_DATA is a valid sample this cycle.
REQ-008 SHALL have port OUT_READY  input  1  consumer accepts OUT_DATA this cycle.
REQ-009 SHALL have port OUT_DATA  output  6  FIFO head code (first-word fall-through).
REQ-010 SHALL have port OUT_VALID  output  1  FIFO non-empty.
REQ-011 SHALL have port COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port FULL  output  1  COUNT == DEPTH.
REQ-013 SHALL have port DROP  output  1  one-cycle pulse: qualified code lost to full FIFO.

Function
REQ-014 SHALL treat code 0 as "no sign" (never stored) and code 63 as "clear" (never stored).
REQ-015 SHALL implement FSM states IDLE, QUALIFY, LATCHED; samples with IN_VALID=0 change no state, counter or candidate.
REQ-016 IDLE: valid nonzero code -> QUALIFY, candidate=code, stable count=1; valid code 0 -> stay IDLE.
REQ-017 QUALIFY: valid sample equal to candidate increments count; valid different nonzero code restarts candidate with count=1; valid code 0 -> IDLE.
REQ-018 On the edge capturing the STABLE_CYCLES-th matching sample (STABLE_CYCLES=1: first sample), SHALL go LATCHED and issue one push of candidate at that same edge.
REQ-019 LATCHED: repeated candidate -> no further push; code 0 -> IDLE; different nonzero code -> QUALIFY, count=1 (so held signs push exactly once).
REQ-020 Qualified code 63 SHALL flush FIFO at that edge (COUNT=0, OUT_VALID=0 next cycle), overriding any same-cycle pop; no push, no DROP.
REQ-021 Pushed code SHALL appear on OUT_DATA with OUT_VALID=1 the cycle after the push edge when FIFO was empty.
REQ-022 Pop occurs on an edge with OUT_VALID=1 and OUT_READY=1; OUT_READY with OUT_VALID=0 SHALL be ignored.
REQ-023 Push and pop on the same edge SHALL both succeed, including when FULL (COUNT unchanged, order preserved).
REQ-024 Push when FULL without pop SHALL be discarded, COUNT unchanged, DROP=1 for exactly the following cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH nor underflow.
REQ-026 OUT_DATA SHALL be 0 whenever OUT_VALID=0.

Reset
REQ-027 RST=1 at an edge SHALL force state IDLE, candidate=0, stable count=0, pointers=0, COUNT=0, OUT_VALID=0, OUT_DATA=0, FULL=0, DROP=0.
REQ-028 RST SHALL dominate all same-cycle pushes, pops and flushes; a qualification in progress SHALL restart from IDLE.

Structure
REQ-029 Package sign_pkg SHALL hold CODE_W=6, CODE_NONE=6'd0, CODE_CLEAR=6'd63 and the FSM state enum typedef.
REQ-030 Storage SHALL be a sub-module char_fifo (sync FIFO, DEPTH, FWFT, push/pop/flush, count); the qualification FSM stays in sign_char_buffer.

Verification
REQ-031 Reset, then IN_DATA=5 valid for 3 cycles -> one push; OUT_VALID=1, OUT_DATA=5 next cycle, COUNT=1.
REQ-032 IN_DATA=5 valid for 10 cycles, then 0, then 5 for 3 -> exactly two entries of 5; samples 5,5,6,6,6 -> single entry 6.
REQ-033 Fill 16 codes with OUT_READY=0, qualify a 17th -> COUNT=16, FULL=1, DROP pulse 1 cycle; then same-edge push+pop at full -> COUNT stays 16, order intact.
REQ-034 Load codes 1,2,3, qualify 63 with OUT_READY=1 -> COUNT=0, OUT_VALID=0 next cycle, 63 never output.
REQ-035 Assert RST after 2 of 3 matching samples with COUNT=4 -> all outputs 0; next 2 matching samples produce no push.
